// File: rtl/cla16_multiword_sequencer_if.sv
// ============================================================================
//  Module   : cla16_multiword_sequencer_if
//  Purpose  : Request/response bundle for the multi-word CLA sequencer.
//             The requesting engine uses the master modport and the sequencer
//             uses the slave modport.
//  Options  : CLA16_SEQ_ZERO_FLAG_EN adds the resp_zero signal.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cla16_multiword_sequencer_if #(
   parameter int WORDS = 4
);
   localparam int W = 16 * WORDS;

   // request channel
   logic          req_valid;
   logic          req_ready;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;
   logic          req_sub;
   logic          req_cin;

   // response channel
   logic          resp_valid;
   logic          resp_ready;
   logic [W-1:0]  resp_sum;
   logic          resp_cout;
   logic          resp_ovf;
`ifdef CLA16_SEQ_ZERO_FLAG_EN
   logic          resp_zero;
`endif

   modport master (
      output req_valid, req_a, req_b, req_sub, req_cin, resp_ready,
      input  req_ready, resp_valid, resp_sum, resp_cout, resp_ovf
`ifdef CLA16_SEQ_ZERO_FLAG_EN
      , input resp_zero
`endif
   );

   modport slave (
      input  req_valid, req_a, req_b, req_sub, req_cin, resp_ready,
      output req_ready, resp_valid, resp_sum, resp_cout, resp_ovf
`ifdef CLA16_SEQ_ZERO_FLAG_EN
      , output resp_zero
`endif
   );

endinterface

`default_nettype wire

// File: rtl/cla16_multiword_sequencer.sv
// ============================================================================
//  Module   : cla16_multiword_sequencer
//  Purpose  : Runs a 16*WORDS-bit add/subtract through one shared external
//             16-bit carry-lookahead adder, one limb per clock, LSB limb
//             first, chaining the carry through a register.
//  Options  : CLA16_SEQ_ZERO_FLAG_EN adds a sticky all-zero result flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cla16_multiword_sequencer #(
   parameter int WORDS = 4                // 1..8 limbs of 16 bits
) (
   input  logic                              clk,
   input  logic                              rst_n,
   cla16_multiword_sequencer_if.slave        bus,
   // shared adder: this block is the only driver of its inputs
   output logic [15:0]                       add_a,
   output logic [15:0]                       add_b,
   output logic                              add_cin,
   input  logic [15:0]                       add_sum,
   input  logic                              add_cout
);

   localparam int            W        = 16 * WORDS;
   localparam int            IW       = $clog2(WORDS) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [IW-1:0]   idx_q;        // limb currently presented to the adder
   logic [W-1:0]    a_q;          // operand A
   logic [W-1:0]    b_q;          // operand B, pre-inverted for subtract
   logic [W-1:0]    sum_q;        // assembled result
   logic            carry_q;      // inter-limb carry, drives add_cin directly
   logic            cout_q;
   logic            ovf_q;
   logic            valid_q;
   logic [15:0]     add_a_q;
   logic [15:0]     add_b_q;
`ifdef CLA16_SEQ_ZERO_FLAG_EN
   logic            zero_q;       // stays 1 while every captured limb is zero
`endif

   logic [W-1:0]    b_d;          // B as it must be stored for this request
   logic            carry_d;      // initial carry: borrow-in becomes ~borrow
   logic            last_d;       // current limb is the most significant one
   logic [IW-1:0]   idx_d;        // next limb index, held on the last limb
   logic [15:0]     nxt_a_d;
   logic [15:0]     nxt_b_d;
   logic            ovf_d;

   // Subtract is A + ~B + 1; a borrow-in removes the +1, hence cin ^ sub.
   // The next-limb index saturates at the top limb so the slice below never
   // reaches past the operand.
   always_comb begin
      b_d     = bus.req_sub ? ~bus.req_b : bus.req_b;
      carry_d = bus.req_cin ^ bus.req_sub;
      last_d  = (idx_q == LAST_IDX);
      idx_d   = last_d ? idx_q : (idx_q + IW'(1'b1));
      nxt_a_d = a_q[{idx_d, 4'b0000} +: 16];
      nxt_b_d = b_q[{idx_d, 4'b0000} +: 16];
      // signed overflow: operands agree in sign, result sign differs
      ovf_d   = (a_q[W-1] == b_q[W-1]) & (add_sum[15] != a_q[W-1]);
   end

   // Sequencer FSM: accept, walk the limbs through the adder, hold the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
         add_a_q <= '0;
         add_b_q <= '0;
`ifdef CLA16_SEQ_ZERO_FLAG_EN
         zero_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.req_valid) begin
                  a_q     <= bus.req_a;
                  b_q     <= b_d;
                  carry_q <= carry_d;
                  idx_q   <= '0;
                  // present limb 0 during the first RUN cycle
                  add_a_q <= bus.req_a[15:0];
                  add_b_q <= b_d[15:0];
`ifdef CLA16_SEQ_ZERO_FLAG_EN
                  zero_q  <= 1'b1;
`endif
                  state_q <= RUN;
               end
            end

            RUN: begin
               sum_q[{idx_q, 4'b0000} +: 16] <= add_sum;
`ifdef CLA16_SEQ_ZERO_FLAG_EN
               zero_q <= zero_q & (add_sum == 16'h0000);
`endif
               if (last_d) begin
                  // final carry goes to the response; adder inputs go quiet
                  cout_q  <= add_cout;
                  ovf_q   <= ovf_d;
                  carry_q <= 1'b0;
                  add_a_q <= '0;
                  add_b_q <= '0;
                  valid_q <= 1'b1;
                  state_q <= DONE;
               end else begin
                  carry_q <= add_cout;
                  idx_q   <= idx_d;
                  add_a_q <= nxt_a_d;
                  add_b_q <= nxt_b_d;
               end
            end

            DONE: begin
               if (bus.resp_ready) begin
                  valid_q <= 1'b0;
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = valid_q;
   assign bus.resp_sum   = sum_q;
   assign bus.resp_cout  = cout_q;
   assign bus.resp_ovf   = ovf_q;
`ifdef CLA16_SEQ_ZERO_FLAG_EN
   assign bus.resp_zero  = zero_q;
`endif

   assign add_a   = add_a_q;
   assign add_b   = add_b_q;
   assign add_cin = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_cla16_multiword_sequencer.sv
// ============================================================================
//  Module   : tb_cla16_multiword_sequencer
//  Purpose  : Directed scoreboard bench for cla16_multiword_sequencer with a
//             behavioural 16-bit adder standing in for the shared CLA.
//  Options  : CLA16_SEQ_ZERO_FLAG_EN enables resp_zero checking.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cla16_multiword_sequencer;

   localparam int WORDS = 4;
   localparam int W     = 16 * WORDS;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   add_a;
   logic [15:0]   add_b;
   logic          add_cin;
   logic [15:0]   add_sum;
   logic          add_cout;

   always #5 clk = ~clk;

   cla16_multiword_sequencer_if #(.WORDS(WORDS)) bus ();

   cla16_multiword_sequencer #(.WORDS(WORDS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout)
   );

   // the shared 16-bit adder
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0000, add_cin};

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         z;
      int           acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
   endtask

   // ---------------- monitor: pops and compares on each response handshake
   initial begin : monitor
      exp_t e;
      logic prev_v;
      int   rise;
      prev_v = 1'b0;
      rise   = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_v = 1'b0;
         end else begin
            if (bus.resp_valid && !prev_v) rise = cyc;
            prev_v = bus.resp_valid;
            if (bus.resp_valid && bus.resp_ready) begin
               if (q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_resp: got sum %h expected no response", bus.resp_sum);
               end else begin
                  e = q.pop_front();
                  chk("resp_sum",  bus.resp_sum,  e.s);
                  chk("resp_cout", W'(bus.resp_cout), W'(e.c));
                  chk("resp_ovf",  W'(bus.resp_ovf),  W'(e.o));
`ifdef CLA16_SEQ_ZERO_FLAG_EN
                  chk("resp_zero", W'(bus.resp_zero), W'(e.z));
`endif
                  chk("latency",   W'(rise - e.acc), W'(WORDS));
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic push_exp(input logic [W-1:0] s, input logic c, input logic o, input logic z);
      exp_t e;
      e.s = s; e.c = c; e.o = o; e.z = z; e.acc = cyc;
      q.push_back(e);
   endtask

   // Returns at accept edge + 1 time unit, expected response already queued.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic cin, input logic [W-1:0] es, input logic ec,
                       input logic eo, input logic ez);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      bus.req_a = a; bus.req_b = b; bus.req_sub = sub; bus.req_cin = cin;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 60 && !got; i++) begin
         @(negedge clk);
         if (bus.req_ready) begin
            @(posedge clk); #1;
            got = 1'b1;
         end
      end
      if (got) push_exp(es, ec, eo, ez);
      else     timeout("accept");
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (q.size() == 0 && !bus.resp_valid) done = 1'b1;
      end
      if (!done) timeout("drain");
   endtask

   // ---------------- directed stimulus
   initial begin : stim
      logic [3:0] cin_seq;
      int         seen;
      bit         got;
      bus.req_valid  = 1'b0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_sub    = 1'b0;
      bus.req_cin    = 1'b0;
      bus.resp_ready = 1'b1;

      // reset state
      #2;
      chk("rst_resp_valid", W'(bus.resp_valid), '0);
      chk("rst_resp_sum",   bus.resp_sum, '0);
      chk("rst_flags",      W'({bus.resp_cout, bus.resp_ovf}), '0);
      chk("rst_adder_in",   W'({add_a, add_b, add_cin}), '0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("rst_req_ready", W'(bus.req_ready), W'(1));

      // 1: carry ripples from limb 0 into limb 1
      send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
      cin_seq = 4'b0010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_add_cin", W'(add_cin), W'(cin_seq[i]));
      end
      // 2: full wrap to zero
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
      // 3: subtract both directions
      send(64'd5, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
      send(64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0, 1'b0);
      // 4: signed overflow both directions
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
      send(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
      // carry-in on add, borrow-in on subtract
      send(64'd1, 64'd2, 1'b0, 1'b1, 64'd4, 1'b0, 1'b0, 1'b0);
      send(64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0, 1'b0);
      drain();

      // 5: back-pressure in DONE with a competing request
      @(posedge clk); #1 bus.resp_ready = 1'b0;
      send(64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.resp_valid) got = 1'b1;
      end
      if (!got) timeout("t5_resp_valid");
      @(posedge clk); #1;
      bus.req_a = 64'd100; bus.req_b = 64'd200; bus.req_sub = 1'b0; bus.req_cin = 1'b0;
      bus.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", W'(bus.resp_valid), W'(1));
         chk("t5_hold_sum",   bus.resp_sum, 64'd7);
         chk("t5_req_ready",  W'(bus.req_ready), '0);
      end
      @(posedge clk); #1 bus.resp_ready = 1'b1;
      @(negedge clk);                          // handshake sampled by monitor
      @(negedge clk);
      chk("t5_idle_ready", W'(bus.req_ready), W'(1));
      chk("t5_idle_valid", W'(bus.resp_valid), '0);
      @(posedge clk); #1;
      push_exp(64'd300, 1'b0, 1'b0, 1'b0);
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk("t5_new_limb0", W'(add_a), W'(16'd100));
      drain();

      // 6: asynchronous reset while limb 2 is in the adder
      send(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0, 1'b0,
           64'h0002_0002_0002_0002, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      chk("t6_limb2", W'(add_a), W'(16'h0001));
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("t6_rst_valid", W'(bus.resp_valid), '0);
      chk("t6_rst_sum",   bus.resp_sum, '0);
      chk("t6_rst_adder", W'({add_a, add_b, add_cin}), '0);
      chk("t6_rst_flags", W'({bus.resp_cout, bus.resp_ovf}), '0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("t6_req_ready", W'(bus.req_ready), W'(1));
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.resp_valid) seen++;
      end
      chk("t6_no_stale", W'(seen), '0);
      send(64'd1, 64'd1, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cla16_multiword_sequencer.md
Name: cla16_multiword_sequencer

Overview:
Sequences wide (16*WORDS-bit) add/subtract operations through one external 16-bit carry-lookahead adder instance, one 16-bit limb per cycle, LSB limb first. The carry is chained between limbs through a register. Requests arrive on a valid/ready port and results leave on a valid/ready port. The block sits between a requesting engine and the shared 16-bit CLA, and is the only driver of that adder's inputs.

Parameters:
- WORDS, 4, number of 16-bit limbs per operand; legal range 1..8; operand width W = 16*WORDS.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  W  operand A.
- req_b  in  W  operand B.
- req_sub  in  1  1 = A - B - req_cin; 0 = A + B + req_cin.
- req_cin  in  1  carry-in (add) or borrow-in (sub).
- resp_valid  out  1  result present.
- resp_ready  in  1  consumer accepts the result.
- resp_sum  out  W  result, modulo 2^W.
- resp_cout  out  1  final carry out of the top limb; for subtract this is the not-borrow flag.
- resp_ovf  out  1  two's-complement signed overflow.
- add_a  out  16  limb driven to the adder's a input.
- add_b  out  16  limb driven to the adder's b input (already inverted for subtract).
- add_cin  out  1  adder carry-in.
- add_sum  in  16  adder sum, combinational from add_a, add_b and add_cin.
- add_cout  in  1  adder carry-out, combinational.

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - state IDLE, limb index 0, carry register 0;
  - resp_valid = 0, resp_sum = 0, resp_cout = 0, resp_ovf = 0;
  - add_a = 0, add_b = 0, add_cin = 0.
  - req_ready is 1 once rst_n is high.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready the block latches:
    - A;
    - B' = req_sub ? ~req_b : req_b;
    - carry register = req_cin ^ req_sub;
    - limb index = 0.
  - The block then goes to RUN.
- RUN:
  - req_ready = 0.
  - add_a = A[16k+15:16k], add_b = B'[16k+15:16k], add_cin = carry register, where k is the limb index.
  - Each clock edge:
    - captures add_sum into result limb k;
    - loads carry register <= add_cout;
    - increments k.
  - After limb WORDS-1 is captured, the block goes to DONE.
  - The block ignores add_sum and add_cout in every other state.
- DONE:
  - resp_valid = 1.
  - resp_sum, resp_cout and resp_ovf stay stable until resp_valid & resp_ready.
  - resp_cout = the carry-out of the last limb.
  - resp_ovf = (A[W-1] == B'[W-1]) & (resp_sum[W-1] != A[W-1]).
  - On the handshake the block returns to IDLE and drops resp_valid in the next cycle.
  - resp_sum holds its last value after the handshake; consumers sample it only while resp_valid = 1.
- Latency: resp_valid rises exactly WORDS cycles after the request-accept edge.
  - Throughput is one operation per WORDS+2 cycles when resp_ready is tied high.
- Adder inputs are driven to 0 in IDLE and DONE.
- req_valid is ignored outside IDLE, and req_a, req_b, req_sub and req_cin are not sampled there.
- WORDS = 1: RUN lasts exactly one cycle.
- Index wrap: the limb index counter is clog2(WORDS)+1 bits wide and never wraps; it resets to 0 on accept.
- Reset asserted mid-RUN or in DONE: the operation is discarded and no response is produced.

Optional Feature:
- Macro: CLA16_SEQ_ZERO_FLAG_EN.
- When defined:
  - adds output port resp_zero (1 bit);
  - a sticky zero register is set to 1 on accept and ANDed with (add_sum == 0) on each RUN capture;
  - resp_zero = 1 iff resp_sum == 0;
  - resp_zero is valid and stable alongside resp_valid;
  - reset value 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan (WORDS=4, W=64):
1. Add, A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> resp_sum=0x0000_0000_0001_0000, cout=0, ovf=0. add_cin across RUN cycles = 0,1,0,0. resp_valid rises exactly 4 cycles after accept.
2. Add, A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 -> resp_sum=0, cout=1, ovf=0, resp_zero=1 (macro defined).
3. Sub, A=5, B=7, cin=0 -> resp_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), ovf=0. Sub, A=7, B=5 -> resp_sum=2, cout=1.
4. Add, A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> resp_sum=0x8000_0000_0000_0000, ovf=1, cout=0. Sub, A=0x8000_0000_0000_0000, B=1 -> resp_sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
5. Hold resp_ready low for 3 cycles in DONE while req_valid=1 with new operands -> resp_valid and outputs stable, req_ready=0, no new accept. After the handshake: IDLE for one cycle, then the new request is accepted.
6. Assert rst_n low during RUN at limb index 2 -> all outputs 0 immediately (asynchronous). After release, req_ready=1 and no stale response appears. A subsequent add of 1+1 returns resp_sum=2.
